mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the single 32-bit memory bus (SRAM plus the 0xFF00xxxx hwreg window) among N_REQ requesters, e.g. the vector core and a UART program loader/DMA.
- Uses round-robin arbitration with a same-cycle grant.
- Tracks ownership of every issued access so that each fixed-latency response (rvalid/err/rdata) goes back only to the requester that issued it.
- Sits between the requesters and the address decoder that drives the RAM and hwreg interface.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- RSP_LAT, 1, fixed downstream cycles from an accepted req to rvalid (1..4).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  N_REQ  per-requester request
- gnt_o  out  N_REQ  one-hot grant; request accepted this cycle
- addr_i  in  N_REQ x ADDR_W  request address
- we_i  in  N_REQ  write enable
- be_i  in  N_REQ x DATA_W/8  byte enables
- wdata_i  in  N_REQ x DATA_W  write data
- rvalid_o  out  N_REQ  response valid, routed to the owner
- err_o  out  N_REQ  response error, qualified by rvalid_o
- rdata_o  out  DATA_W  response data, broadcast, qualified by rvalid_o
- mem_req_o  out  1  downstream request
- mem_addr_o  out  ADDR_W  downstream address
- mem_we_o  out  1  downstream write enable
- mem_be_o  out  DATA_W/8  downstream byte enables
- mem_wdata_o  out  DATA_W  downstream write data
- mem_rvalid_i  in  1  downstream response valid
- mem_err_i  in  1  downstream response error
- mem_rdata_i  in  DATA_W  downstream read data
- spurious_o  out  1  sticky flag: downstream response arrived with no owner

Behaviour:
- Downstream accepts one request per cycle and never stalls.
- mem_req_o = OR of req_i. When mem_req_o is 0, all mem_* outputs are 0.
- Arbitration is combinational within the cycle.
  - Search starts at index (last_q+1) mod N_REQ and takes the first asserted req_i.
  - gnt_o is one-hot with that index; mem_* carry that requester's fields.
- last_q updates to the granted index on every grant and holds otherwise.
  - Reset value is N_REQ-1, so requester 0 wins the first contention.
- A requester must hold req_i and its fields stable until gnt_o.
  - Dropping req_i before grant is legal; nothing is issued for it.
  - gnt_o never asserts without req_i.
- A single active requester is granted every cycle (back-to-back, no bubbles).
- Owner pipeline: RSP_LAT-deep shift register of {valid, id}, advancing every cycle.
  - Stage 0 loads {mem_req_o, granted index}.
  - The head entry (stage RSP_LAT-1) is compared against mem_rvalid_i.
- Response routing:
  - rvalid_o[i] = mem_rvalid_i & head.valid & head.id==i.
  - err_o[i] = rvalid_o[i] & mem_err_i.
  - rdata_o = mem_rdata_i. Response latency is unchanged by the arbiter, i.e. RSP_LAT.
- mem_rvalid_i with head.valid=0: response is dropped, no rvalid_o, spurious_o set (sticky until reset).
- head.valid=1 without mem_rvalid_i: no rvalid_o; that access is lost. Downstream is required to always respond.
- A grant and a response to the same requester in the same cycle are independent; both happen.
- Reset (async, any time):
  - gnt_o, rvalid_o, err_o, mem_req_o, spurious_o = 0.
  - Pipeline cleared and in-flight ownership discarded.
  - Responses arriving after reset set spurious_o.

Optional Feature:
- Macro: MEM_BUS_ARBITER_STATS_EN.
- Defined:
  - Extra ports stat_clr_i (in, 1) and stat_wait_o (out, N_REQ x 32).
  - Per-requester 32-bit saturating counter increments each cycle req_i[i] & ~gnt_o[i].
  - stat_clr_i zeroes all counters; clear wins over increment.
  - Counters reset to 0.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef owner_entry_t {logic valid; logic [2:0] id;}
  - constant MAX_REQ = 8
  - constant STAT_W = 32
- Sub-module mem_arb_rr_pick: combinational round-robin picker taking req vector and last index, producing one-hot grant and index.

Test Plan:
- Reset release, N_REQ=2, req_i=2'b11 held -> gnt_o sequence 01,10,01,10. Each response returns to the issuer 1 cycle after grant, with rdata matching the address written earlier.
- Only req_i[1] asserted for 5 cycles -> gnt_o[1] every cycle. Then req_i=2'b11 -> next grant goes to 0.
- RSP_LAT=3, alternating writes from 0 and 1 to 0x100/0x104, then reads -> rvalid_o routed correctly 3 cycles after each grant; no cross-delivery.
- Access to unmapped address 0x2000_0000 by requester 1 (mem_err_i=1) -> rvalid_o[1]=1, err_o[1]=1, err_o[0]=0.
- Inject mem_rvalid_i with no outstanding request; also assert rst_n low between grant and response -> spurious_o=1, no rvalid_o.
- With MEM_BUS_ARBITER_STATS_EN, both requesting for 10 cycles -> stat_wait_o[0]=5, [1]=5. stat_clr_i together with a waiting cycle -> 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
//   owner_entry_t : one stage of the response-ownership pipeline {valid, id}
//   MAX_REQ       : upper bound on requester count (id is 3 bits wide)
//   STAT_W        : width of the optional per-requester wait counters
//   lowest_set()  : index of the least-significant set bit of a MAX_REQ vector
package mem_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int STAT_W  = 32;

    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } owner_entry_t;

    function automatic logic [2:0] lowest_set(input logic [MAX_REQ-1:0] v);
        logic [2:0] r;
        logic       found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (!found && v[3'(i)]) begin
                r     = 3'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and downstream-side signals of the memory bus arbiter.
//   slave  : the arbiter's view (takes requests/responses, drives grants/mem_*)
//   master : the environment's view (requesters plus downstream decoder)
interface mem_bus_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [N_REQ-1:0]                   req_i;
    logic [N_REQ-1:0]                   gnt_o;
    logic [N_REQ-1:0][ADDR_W-1:0]       addr_i;
    logic [N_REQ-1:0]                   we_i;
    logic [N_REQ-1:0][DATA_W/8-1:0]     be_i;
    logic [N_REQ-1:0][DATA_W-1:0]       wdata_i;
    logic [N_REQ-1:0]                   rvalid_o;
    logic [N_REQ-1:0]                   err_o;
    logic [DATA_W-1:0]                  rdata_o;
    logic                               mem_req_o;
    logic [ADDR_W-1:0]                  mem_addr_o;
    logic                               mem_we_o;
    logic [DATA_W/8-1:0]                mem_be_o;
    logic [DATA_W-1:0]                  mem_wdata_o;
    logic                               mem_rvalid_i;
    logic                               mem_err_i;
    logic [DATA_W-1:0]                  mem_rdata_i;
    logic                               spurious_o;

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        input  mem_rvalid_i, mem_err_i, mem_rdata_i,
        output gnt_o, rvalid_o, err_o, rdata_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output spurious_o
    );

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        output mem_rvalid_i, mem_err_i, mem_rdata_i,
        input  gnt_o, rvalid_o, err_o, rdata_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  spurious_o
    );

endinterface

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin picker.
//   req  : request vector
//   last : index granted most recently
//   gnt  : one-hot grant (zero when no request)
//   idx  : granted index (0 when no request)
module mem_arb_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       last,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       idx
);

    logic [MAX_REQ-1:0] req_w;
    logic [MAX_REQ-1:0] above;
    logic [MAX_REQ-1:0] sel;

    // Requests strictly above 'last' win; otherwise wrap to the lowest request.
    always_comb begin
        req_w = MAX_REQ'(req);
        above = req_w & ~((MAX_REQ'(2) << last) - MAX_REQ'(1));
        sel   = (|above) ? above : req_w;
        idx   = lowest_set(sel);
        gnt   = (|req) ? N_REQ'(MAX_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus among N_REQ requesters, with
// fixed-latency response routing back to the issuing requester.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_bus_arbiter_if.slave (requests, grants, responses, mem_*)
// Optional (MEM_BUS_ARBITER_STATS_EN defined):
//   stat_clr_i  : clears all wait counters (wins over increment)
//   stat_wait_o : per-requester saturating count of cycles spent waiting
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RSP_LAT = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    mem_bus_arbiter_if.slave                 bus
`ifdef MEM_BUS_ARBITER_STATS_EN
    ,
    input  logic                             stat_clr_i,
    output logic [N_REQ-1:0][STAT_W-1:0]     stat_wait_o
`endif
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]             req_eff;
    logic [N_REQ-1:0]             gnt;
    logic [2:0]                   gnt_idx;
    logic [2:0]                   last_q;
    logic                         mem_req;
    logic [ADDR_W-1:0]            addr_mux;
    logic                         we_mux;
    logic [DATA_W/8-1:0]          be_mux;
    logic [DATA_W-1:0]            wdata_mux;
    owner_entry_t                 new_entry;
    owner_entry_t [RSP_LAT-1:0]   pipe_q;
    owner_entry_t [RSP_LAT:0]     pipe_ext;
    owner_entry_t                 head;
    logic [N_REQ-1:0]             rvalid;
    logic                         spurious_q;

    // Requests are masked during reset so no grant or mem_req escapes.
    assign req_eff = rst_n ? bus.req_i : '0;

    mem_arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req  (req_eff),
        .last (last_q),
        .gnt  (gnt),
        .idx  (gnt_idx)
    );

    assign mem_req = |req_eff;

    // One-hot AND-OR mux; all fields fall to zero when nothing is granted.
    always_comb begin
        addr_mux  = '0;
        we_mux    = 1'b0;
        be_mux    = '0;
        wdata_mux = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[IW'(i)]) begin
                addr_mux  = addr_mux  | bus.addr_i[IW'(i)];
                we_mux    = we_mux    | bus.we_i[IW'(i)];
                be_mux    = be_mux    | bus.be_i[IW'(i)];
                wdata_mux = wdata_mux | bus.wdata_i[IW'(i)];
            end
        end
    end

    assign new_entry.valid = mem_req;
    assign new_entry.id    = gnt_idx;
    assign pipe_ext        = {pipe_q, new_entry};
    assign head            = pipe_q[RSP_LAT-1];

    always_comb begin
        rvalid = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rvalid[IW'(i)] = bus.mem_rvalid_i && head.valid && (head.id == 3'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= 3'(N_REQ - 1);
            pipe_q     <= '0;
            spurious_q <= 1'b0;
        end else begin
            if (mem_req) begin
                last_q <= gnt_idx;
            end
            pipe_q <= pipe_ext[RSP_LAT-1:0];
            if (bus.mem_rvalid_i && !head.valid) begin
                spurious_q <= 1'b1;
            end
        end
    end

    assign bus.gnt_o       = gnt;
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_addr_o  = addr_mux;
    assign bus.mem_we_o    = we_mux;
    assign bus.mem_be_o    = be_mux;
    assign bus.mem_wdata_o = wdata_mux;
    assign bus.rvalid_o    = rvalid;
    assign bus.err_o       = rvalid & {N_REQ{bus.mem_err_i}};
    assign bus.rdata_o     = bus.mem_rdata_i;
    assign bus.spurious_o  = spurious_q;

`ifdef MEM_BUS_ARBITER_STATS_EN
    logic [N_REQ-1:0][STAT_W-1:0] wait_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if (stat_clr_i) begin
            wait_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (req_eff[IW'(i)] && !gnt[IW'(i)] && (wait_q[IW'(i)] != '1)) begin
                    wait_q[IW'(i)] <= wait_q[IW'(i)] + STAT_W'(1);
                end
            end
        end
    end

    assign stat_wait_o = wait_q;
`endif

endmodule
